// File: rtl/tdm_decoder.sv
// Receive side of the 3-channel TDM link: frames the serial stream on sync_in and
// recovers three channel words. Optional err_count output under TDM_DECODER_ERR_CNT_EN.
module tdm_decoder #(
  parameter int unsigned CH_WIDTH    = 8,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                serial_in,
  input  logic                sync_in,
  output logic [CH_WIDTH-1:0] channel1,
  output logic [CH_WIDTH-1:0] channel2,
  output logic [CH_WIDTH-1:0] channel3,
  output logic                frame_valid,
  output logic                locked,
  output logic                frame_err
`ifdef TDM_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]         err_count
`endif
);

  localparam int unsigned FrameLen = 3 * CH_WIDTH;
  localparam int unsigned CntW     = $clog2(FrameLen);
  localparam logic [CntW-1:0] LastCnt = CntW'(FrameLen - 1);
  localparam logic [CntW-1:0] OneCnt  = CntW'(1);
  localparam logic [3:0]      LockThr = 4'(LOCK_FRAMES);

  typedef enum logic [0:0] {StHunt, StShift} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [FrameLen-2:0] shift_q;
  logic [3:0]          good_q;
  logic [3:0]          good_inc;
  logic                err_hit;
  logic [FrameLen-2:0] first_bit;

  assign good_inc  = (good_q >= LockThr) ? good_q : good_q + 4'd1;
  assign first_bit = {{(FrameLen - 2){1'b0}}, serial_in};

  // Early sync mid-frame, or no sync where a frame boundary is due.
  assign err_hit = (state_q == StShift) && (sync_in ? (cnt_q != '0) : (cnt_q == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StHunt;
      cnt_q       <= '0;
      shift_q     <= '0;
      good_q      <= '0;
      channel1    <= '0;
      channel2    <= '0;
      channel3    <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (err_hit) begin
        frame_err <= 1'b1;
        good_q    <= '0;
        locked    <= 1'b0;
      end
      unique case (state_q)
        StHunt: begin
          if (sync_in) begin
            shift_q <= first_bit;
            cnt_q   <= OneCnt;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (sync_in) begin
            // Any sync restarts framing here; a partial frame is dropped.
            shift_q <= first_bit;
            cnt_q   <= OneCnt;
          end else if (cnt_q == '0) begin
            state_q <= StHunt;
          end else if (cnt_q == LastCnt) begin
            {channel1, channel2, channel3} <= {shift_q, serial_in};
            frame_valid <= 1'b1;
            good_q      <= good_inc;
            locked      <= (good_inc >= LockThr);
            cnt_q       <= '0;
          end else begin
            shift_q <= {shift_q[FrameLen-3:0], serial_in};
            cnt_q   <= cnt_q + OneCnt;
          end
        end
      endcase
    end
  end

`ifdef TDM_DECODER_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_hit && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tdm_decoder.sv
// Scoreboard bench for tdm_decoder: frame-level stimulus model predicts strobes and data.
module tb_tdm_decoder;
  localparam int W    = 8;
  localparam int LOCK = 2;
  localparam int FL   = 3 * W;

  logic         clk = 1'b0;
  logic         rst;
  logic         serial_in;
  logic         sync_in;
  logic [W-1:0] channel1, channel2, channel3;
  logic         frame_valid, locked, frame_err;
`ifdef TDM_DECODER_ERR_CNT_EN
  logic [15:0]  err_count;
`endif

  tdm_decoder #(.CH_WIDTH(W), .LOCK_FRAMES(LOCK)) dut (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .sync_in    (sync_in),
    .channel1   (channel1),
    .channel2   (channel2),
    .channel3   (channel3),
    .frame_valid(frame_valid),
    .locked     (locked),
    .frame_err  (frame_err)
`ifdef TDM_DECODER_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Line situation as seen by the sender: hunting, just finished a frame, or mid-frame.
  typedef enum {MHunt, MBoundary, MPartial} mstate_e;
  typedef struct {time t; logic [W-1:0] a, b, c; logic lk;} vexp_t;
  typedef struct {time t; logic [W-1:0] a, b, c; int n;} eexp_t;

  mstate_e      mst;
  int           good;
  int           errs;
  logic [W-1:0] last_a, last_b, last_c;
  vexp_t        vq[$];
  eexp_t        eq[$];
  int           checks   = 0;
  int           failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic b, input logic s, output time t);
    serial_in = b;
    sync_in   = s;
    @(posedge clk);
    t = $time;
    #1;
  endtask

  task automatic push_err(input time t);
    eexp_t e;
    errs++;
    good = 0;
    e.t = t + 5; e.a = last_a; e.b = last_b; e.c = last_c; e.n = errs;
    eq.push_back(e);
  endtask

  task automatic send_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] c);
    logic [FL-1:0] bits;
    time           t;
    vexp_t         v;
    bits = {a, b, c};
    for (int i = 0; i < FL; i++) begin
      drive(bits[FL-1-i], i == 0, t);
      if (i == 0 && mst == MPartial) push_err(t);
      if (i == FL - 1) begin
        if (good < LOCK) good++;
        last_a = a; last_b = b; last_c = c;
        v.t = t + 5; v.a = a; v.b = b; v.c = c; v.lk = (good >= LOCK);
        vq.push_back(v);
      end
    end
    mst = MBoundary;
  endtask

  task automatic send_partial(input int n);
    time t;
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 1)), i == 0, t);
      if (i == 0 && mst == MPartial) push_err(t);
    end
    mst = MPartial;
  endtask

  // Caller guarantees the line is not mid-frame.
  task automatic send_idle(input int n);
    time t;
    for (int i = 0; i < n; i++) begin
      drive(1'(i % 2), 1'b0, t);
      if (i == 0 && mst == MBoundary) begin
        push_err(t);
        mst = MHunt;
      end
    end
  endtask

  task automatic do_reset();
    time t;
    rst = 1'b1;
    #1;
    chk("rst_ch1", 32'(channel1), 0);
    chk("rst_ch2", 32'(channel2), 0);
    chk("rst_ch3", 32'(channel3), 0);
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_err", 32'(frame_err), 0);
`ifdef TDM_DECODER_ERR_CNT_EN
    chk("rst_err_count", 32'(err_count), 0);
`endif
    vq.delete();
    eq.delete();
    good = 0; errs = 0; mst = MHunt;
    last_a = '0; last_b = '0; last_c = '0;
    drive(1'b0, 1'b0, t);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (vq.size() > 0 && vq[0].t < $time) begin
        chk("missed_valid", 32'(vq[0].t), 32'($time));
        void'(vq.pop_front());
      end
      while (eq.size() > 0 && eq[0].t < $time) begin
        chk("missed_err", 32'(eq[0].t), 32'($time));
        void'(eq.pop_front());
      end
      if (frame_valid && frame_err) chk("valid_and_err", 32'(1), 0);
      if (frame_valid) begin
        if (vq.size() == 0 || vq[0].t != $time) begin
          chk("unexpected_valid", 32'(frame_valid), 0);
        end else begin
          vexp_t v;
          v = vq.pop_front();
          chk("ch1", 32'(channel1), 32'(v.a));
          chk("ch2", 32'(channel2), 32'(v.b));
          chk("ch3", 32'(channel3), 32'(v.c));
          chk("locked_at_valid", 32'(locked), 32'(v.lk));
        end
      end
      if (frame_err) begin
        if (eq.size() == 0 || eq[0].t != $time) begin
          chk("unexpected_err", 32'(frame_err), 0);
        end else begin
          eexp_t e;
          e = eq.pop_front();
          chk("locked_at_err", 32'(locked), 0);
          chk("ch1_hold", 32'(channel1), 32'(e.a));
          chk("ch2_hold", 32'(channel2), 32'(e.b));
          chk("ch3_hold", 32'(channel3), 32'(e.c));
`ifdef TDM_DECODER_ERR_CNT_EN
          chk("err_count", 32'(err_count), 32'(e.n));
`endif
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    time t;
    rst = 1'b1; serial_in = 1'b0; sync_in = 1'b0;
    mst = MHunt; good = 0; errs = 0;
    last_a = '0; last_b = '0; last_c = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Encoder pattern, lock on second frame.
    repeat (3) send_frame(8'hAA, 8'hCC, 8'hF0);
    // Idle line, then a fresh frame.
    send_idle(100);
    send_frame(8'h12, 8'h34, 8'h56);
    send_frame(8'h9A, 8'hBC, 8'hDE);
    // Early sync at bit 10.
    send_partial(10);
    send_frame(8'h5A, 8'hA5, 8'h3C);
    send_frame(8'hC3, 8'h0F, 8'h11);
    // Missing sync at the boundary, then relock.
    send_idle(5);
    send_frame(8'h22, 8'h44, 8'h66);
    send_frame(8'h77, 8'h88, 8'h99);
    // Reset mid-frame at bit 15.
    send_partial(15);
    do_reset();
    send_frame(8'h01, 8'h80, 8'hFF);
    // Three early syncs in a row.
    send_partial(5);
    send_partial(7);
    send_partial(3);
    send_frame(8'hE1, 8'h2D, 8'h4B);
`ifdef TDM_DECODER_ERR_CNT_EN
    chk("err_count_three", 32'(err_count), 3);
`endif
    do_reset();

    for (int k = 0; k < 300; k++) begin
      op = int'($urandom_range(0, 9));
      if (op == 9 && $urandom_range(0, 3) != 0) op = 0;
      if (op == 8 && mst == MPartial) op = 0;
      case (op)
        6, 7: send_partial(int'($urandom_range(1, FL - 1)));
        8: send_idle(int'($urandom_range(1, 30)));
        9: do_reset();
        default: send_frame(W'($urandom), W'($urandom), W'($urandom));
      endcase
    end

    send_frame(8'h3E, 8'h7F, 8'h01);
    send_idle(5);
    repeat (3) drive(1'b0, 1'b0, t);
    chk("valid_queue_drained", 32'(vq.size()), 0);
    chk("err_queue_drained", 32'(eq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
